// File: rtl/bus_resp_mem.sv
// CODMA bus responder: word-addressed 32-bit memory serving 64-bit read/write beats.
// One request is handled at a time. A backdoor port gives preload and inspection access.
module bus_resp_mem #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned GRANT_DELAY = 0,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         bus_read_i,
  input  logic                         bus_write_i,
  input  logic [31:0]                  bus_addr_i,
  input  logic [7:0]                   bus_size_i,
  input  logic                         bus_write_valid_i,
  input  logic [63:0]                  bus_write_data_i,
  output logic                         bus_grant_o,
  output logic                         bus_read_valid_o,
  output logic [63:0]                  bus_read_data_o,
  output logic                         bus_error_o,
  output logic                         busy_o,
  input  logic                         bd_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_idx_i,
  input  logic [31:0]                  bd_wdata_i,
  output logic [31:0]                  bd_rdata_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DELAY   = 3'd1;
  localparam logic [2:0] S_GRANT   = 3'd2;
  localparam logic [2:0] S_ERR     = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_RD_BEAT = 3'd5;
  localparam logic [2:0] S_WR_BEAT = 3'd6;

  logic [31:0] mem_q [MEM_WORDS];

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  beat_q, beat_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  size_q, size_d;
  logic        is_rd_q, is_rd_d;
  logic        grant_q, grant_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [63:0] rdata_q, rdata_d;

  logic          size_ok;
  logic [2:0]    last_beat;
  logic [31:0]   word_end;
  logic          illegal;
  logic [AW-1:0] base_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic [AW-1:0] rd_idx;

  // Decode of the latched request: beat count and legality.
  always_comb begin
    size_ok   = 1'b1;
    last_beat = 3'd0;
    case (size_q)
      8'd3:    last_beat = 3'd0;
      8'd8:    last_beat = 3'd1;
      8'd9:    last_beat = 3'd3;
      default: size_ok   = 1'b0;
    endcase
  end

  // Word index one past the last word touched; checked against the array depth.
  assign word_end = 32'(addr_q[31:2]) + 32'({last_beat, 1'b0}) + 32'd2;
  assign illegal  = !size_ok || (addr_q[2:0] != 3'd0) || (word_end > 32'(MEM_WORDS));
  assign base_idx = addr_q[AW+1:2];
  assign wr_idx   = base_idx + AW'({beat_q, 1'b0});
  assign wr_en    = (state_q == S_WR_BEAT) && bus_write_valid_i;

  // Memory: bus write is ordered after the backdoor write so it wins on a collision.
  always_ff @(posedge clk_i) begin
    if (bd_we_i) begin
      mem_q[bd_idx_i] <= bd_wdata_i;
    end
    if (wr_en) begin
      mem_q[wr_idx]           <= bus_write_data_i[31:0];
      mem_q[wr_idx + AW'(1)]  <= bus_write_data_i[63:32];
    end
  end

  assign bd_rdata_o = mem_q[bd_idx_i];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      beat_q   <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      is_rd_q  <= 1'b0;
      grant_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      is_rd_q  <= is_rd_d;
      grant_q  <= grant_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next state; outputs are registered from the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    size_d  = size_q;
    is_rd_d = is_rd_q;
    rdata_d = rdata_q;
    rd_idx  = '0;

    case (state_q)
      S_IDLE: begin
        if (bus_read_i || bus_write_i) begin
          addr_d  = bus_addr_i;
          size_d  = bus_size_i;
          is_rd_d = bus_read_i;
          cnt_d   = '0;
          beat_d  = '0;
          state_d = (GRANT_DELAY > 0) ? S_DELAY : S_GRANT;
        end
      end
      S_DELAY: begin
        if (cnt_q == 32'(GRANT_DELAY - 1)) begin
          state_d = S_GRANT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_GRANT: begin
        cnt_d  = '0;
        beat_d = '0;
        if (illegal) begin
          state_d = S_ERR;
        end else if (is_rd_q) begin
          state_d = (RD_LATENCY > 0) ? S_RD_WAIT : S_RD_BEAT;
        end else begin
          state_d = S_WR_BEAT;
        end
      end
      S_ERR: state_d = S_IDLE;
      S_RD_WAIT: begin
        if (cnt_q == 32'(RD_LATENCY - 1)) begin
          state_d = S_RD_BEAT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RD_BEAT: begin
        if (beat_q == last_beat) begin
          state_d = S_IDLE;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      S_WR_BEAT: begin
        if (bus_write_valid_i) begin
          if (beat_q == last_beat) begin
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    grant_d  = (state_d == S_GRANT);
    err_d    = (state_d == S_ERR);
    rvalid_d = (state_d == S_RD_BEAT);
    busy_d   = (state_d != S_IDLE);

    // Fetch the beat that will be presented next cycle; hold data otherwise.
    if (rvalid_d) begin
      rd_idx  = base_idx + AW'({beat_d, 1'b0});
      rdata_d = {mem_q[rd_idx + AW'(1)], mem_q[rd_idx]};
    end
  end

  assign bus_grant_o      = grant_q;
  assign bus_read_valid_o = rvalid_q;
  assign bus_read_data_o  = rdata_q;
  assign bus_error_o      = err_q;
  assign busy_o           = busy_q;

endmodule
